// File: rtl/lc3b_types.sv
// Shared types for the multiport nonblocking cache pmem-side logic.
// Holds the scheduler state enum used by mpnc_pmem_scheduler.
// No logic here; types and constants only.
package lc3b_types;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_FILL_REQ = 3'd2,
    S_EVICT    = 3'd3,
    S_FILL     = 3'd4,
    S_WRITE    = 3'd5
  } lc3b_mpnc_sched_state;

endpackage

// File: rtl/mpnc_pmem_scheduler.sv
// Chooses between MSHR line fills and RPB writebacks on the single pmem port,
// then installs a returned line into the two-way arrays (evicting a dirty victim).
// Latency: pmem latency + >=1 grant wait + optional evict + 1 install; holds on missing grant/resp.
module mpnc_pmem_scheduler
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mshr_wait,
  input  logic       mshr_dirty,
  input  logic       rpb_wait,
  input  logic       rpb_full,
  input  logic       pmem_resp,
  input  logic       lru_out,
  input  logic [1:0] victim_dirty,
  input  logic       fill_grant,
  output logic       pmem_read,
  output logic       pmem_write,
  output logic       rw_sel,
  output logic       mshr_load_line,
  output logic       inc_mshr_ptr,
  output logic       inc_rpb_ptr,
  output logic       rpb_load_line,
  output logic       fill_req,
  output logic [1:0] load_data,
  output logic [1:0] load_valid,
  output logic [1:0] load_dirty,
  output logic [1:0] dirty_in,
  output logic       update_lru,
  output logic       lru_in,
  output logic       load_dirty_sel
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  lc3b_mpnc_sched_state state, next_state;
  logic [CW-1:0]        starve_cnt;
  logic                 way;
  logic [1:0]           way_mask;

  // State, latched victim way and saturating fill-starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
      way        <= 1'b0;
    end else begin
      state <= next_state;
      // The last value sampled in FILL_REQ is the one carried into EVICT/FILL.
      if (state == S_FILL_REQ) begin
        way <= lru_out;
      end
      if (state == S_IDLE && (next_state == S_WRITE || !rpb_wait)) begin
        starve_cnt <= '0;
      end else if (state == S_FILL && rpb_wait && starve_cnt != CW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

  // Next-state arbitration and Moore output decode; pulses tied to pmem_resp.
  always_comb begin
    next_state     = state;
    way_mask       = way ? 2'b10 : 2'b01;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    rw_sel         = 1'b1;
    mshr_load_line = 1'b0;
    inc_mshr_ptr   = 1'b0;
    inc_rpb_ptr    = 1'b0;
    rpb_load_line  = 1'b0;
    fill_req       = 1'b0;
    load_data      = 2'b00;
    load_valid     = 2'b00;
    load_dirty     = 2'b00;
    dirty_in       = 2'b00;
    update_lru     = 1'b0;
    lru_in         = 1'b0;
    load_dirty_sel = 1'b0;
    case (state)
      S_IDLE: begin
        // A full RPB must drain first; otherwise fills win until they starve writebacks.
        if (rpb_wait && rpb_full) begin
          next_state = S_WRITE;
        end else if (mshr_wait && starve_cnt < CW'(STARVE_LIMIT)) begin
          next_state = S_READ;
        end else if (rpb_wait) begin
          next_state = S_WRITE;
        end else if (mshr_wait) begin
          next_state = S_READ;
        end
      end
      S_READ: begin
        pmem_read = 1'b1;
        // Reset abandons the transfer without committing the line.
        mshr_load_line = pmem_resp && !reset;
        if (pmem_resp) begin
          next_state = S_FILL_REQ;
        end
      end
      S_FILL_REQ: begin
        fill_req       = 1'b1;
        load_dirty_sel = 1'b1;
        // A dirty victim with nowhere to go leaves us waiting even when granted.
        if (fill_grant) begin
          if (!victim_dirty[lru_out]) begin
            next_state = S_FILL;
          end else if (!rpb_full) begin
            next_state = S_EVICT;
          end
        end
      end
      S_EVICT: begin
        fill_req      = 1'b1;
        rpb_load_line = 1'b1;
        next_state    = S_FILL;
      end
      S_FILL: begin
        fill_req     = 1'b1;
        load_data    = way_mask;
        load_valid   = way_mask;
        load_dirty   = way_mask;
        dirty_in     = mshr_dirty ? way_mask : 2'b00;
        update_lru   = 1'b1;
        lru_in       = ~way;
        inc_mshr_ptr = 1'b1;
        next_state   = S_IDLE;
      end
      S_WRITE: begin
        pmem_write  = 1'b1;
        rw_sel      = 1'b0;
        inc_rpb_ptr = pmem_resp && !reset;
        if (pmem_resp) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mpnc_pmem_scheduler.sv
// Self-checking bench for mpnc_pmem_scheduler: directed scenarios then random traffic.
// Reference model tracks transaction phase, victim way and starvation count from the rules.
// Inputs driven 1 time unit after posedge, outputs compared at negedge.
module tb_mpnc_pmem_scheduler;

  localparam int LIM = 4;
  localparam int PH_IDLE = 0, PH_MEMRD = 1, PH_GRANT = 2, PH_EVICT = 3, PH_INSTALL = 4, PH_MEMWR = 5;
  localparam logic [18:0] RST_VEC = 19'h1_0000;

  logic clk;
  logic reset;
  logic mshr_wait, mshr_dirty, rpb_wait, rpb_full, pmem_resp, lru_out, fill_grant;
  logic [1:0] victim_dirty;
  logic pmem_read, pmem_write, rw_sel, mshr_load_line, inc_mshr_ptr, inc_rpb_ptr;
  logic rpb_load_line, fill_req, update_lru, lru_in, load_dirty_sel;
  logic [1:0] load_data, load_valid, load_dirty, dirty_in;

  int n_chk = 0;
  int n_fail = 0;

  // reference model / environment state
  int ph = PH_IDLE;
  int mw = 0;
  int sc = 0;
  int fills = 0;
  int wbs = 0;

  mpnc_pmem_scheduler #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .mshr_wait(mshr_wait), .mshr_dirty(mshr_dirty), .rpb_wait(rpb_wait), .rpb_full(rpb_full),
    .pmem_resp(pmem_resp), .lru_out(lru_out), .victim_dirty(victim_dirty), .fill_grant(fill_grant),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .rw_sel(rw_sel),
    .mshr_load_line(mshr_load_line), .inc_mshr_ptr(inc_mshr_ptr), .inc_rpb_ptr(inc_rpb_ptr),
    .rpb_load_line(rpb_load_line), .fill_req(fill_req),
    .load_data(load_data), .load_valid(load_valid), .load_dirty(load_dirty), .dirty_in(dirty_in),
    .update_lru(update_lru), .lru_in(lru_in), .load_dirty_sel(load_dirty_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] obs();
    return {pmem_read, pmem_write, rw_sel, mshr_load_line, inc_mshr_ptr, inc_rpb_ptr,
            rpb_load_line, fill_req, load_data, load_valid, load_dirty, dirty_in,
            update_lru, lru_in, load_dirty_sel};
  endfunction

  task automatic clr();
    mshr_wait = 0; mshr_dirty = 0; rpb_wait = 0; rpb_full = 0;
    pmem_resp = 0; lru_out = 0; fill_grant = 0; victim_dirty = 2'b00;
  endtask

  // Compare every output against the model at negedge, then advance the model.
  task automatic settle();
    logic [18:0] ev;
    logic [1:0]  m;
    @(negedge clk);
    m  = (mw == 1) ? 2'b10 : 2'b01;
    ev = RST_VEC;
    case (ph)
      PH_MEMRD:   begin ev[18] = 1'b1; ev[15] = pmem_resp && !reset; end
      PH_GRANT:   begin ev[11] = 1'b1; ev[0] = 1'b1; end
      PH_EVICT:   begin ev[11] = 1'b1; ev[12] = 1'b1; end
      PH_INSTALL: begin
        ev[11] = 1'b1; ev[14] = 1'b1; ev[2] = 1'b1; ev[1] = (mw == 0);
        ev[10:9] = m; ev[8:7] = m; ev[6:5] = m; ev[4:3] = mshr_dirty ? m : 2'b00;
      end
      PH_MEMWR:   begin ev[17] = 1'b1; ev[16] = 1'b0; ev[13] = pmem_resp && !reset; end
      default:    ;
    endcase
    chk($sformatf("outs_ph%0d", ph), 32'(obs()), 32'(ev));

    if (reset) begin
      ph = PH_IDLE; sc = 0; mw = 0;
    end else begin
      case (ph)
        PH_IDLE: begin
          if (rpb_wait && (rpb_full || !(mshr_wait && sc < LIM))) begin
            ph = PH_MEMWR; sc = 0;
          end else if (mshr_wait) begin
            ph = PH_MEMRD;
          end
          if (!rpb_wait) sc = 0;
        end
        PH_MEMRD: if (pmem_resp) ph = PH_GRANT;
        PH_GRANT: begin
          if (fill_grant && !victim_dirty[lru_out]) begin
            ph = PH_INSTALL; mw = int'(lru_out);
          end else if (fill_grant && !rpb_full) begin
            ph = PH_EVICT; mw = int'(lru_out);
          end
        end
        PH_EVICT: begin ph = PH_INSTALL; wbs++; end
        PH_INSTALL: begin
          if (rpb_wait && sc < LIM) sc++;
          if (fills > 0) fills--;
          ph = PH_IDLE;
        end
        PH_MEMWR: if (pmem_resp) begin ph = PH_IDLE; if (wbs > 0) wbs--; end
        default: ph = PH_IDLE;
      endcase
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    reset = 1;
    settle(); adv();
    reset = 0;
  endtask

  initial begin
    int nfill;
    bit seen_wr;
    bit mll_seen;

    clr();
    reset = 1;
    @(posedge clk); #1;
    settle(); adv();
    reset = 0;
    settle();
    chk("rst_vec", 32'(obs()), 32'(RST_VEC));
    adv();

    // clean-victim fill into way1, 3-cycle pmem latency
    do_reset();
    mshr_wait = 1; lru_out = 1; victim_dirty = 2'b00; fill_grant = 1;
    settle(); adv();
    mshr_wait = 0;
    settle(); adv(); settle(); adv();
    pmem_resp = 1;
    settle(); chk("t1_mll", 32'(mshr_load_line), 1); adv();
    pmem_resp = 0;
    settle(); adv();
    settle();
    chk("t1_load_data", 32'(load_data), 2);
    chk("t1_load_valid", 32'(load_valid), 2);
    chk("t1_lru_in", 32'(lru_in), 0);
    chk("t1_inc_mshr", 32'(inc_mshr_ptr), 1);
    adv();

    // dirty victim with full RPB holds, then evicts once RPB frees
    do_reset();
    mshr_wait = 1; lru_out = 0; victim_dirty = 2'b01; rpb_full = 1; fill_grant = 1;
    settle(); adv();
    mshr_wait = 0; pmem_resp = 1;
    settle(); adv();
    pmem_resp = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t2_hold", 32'(load_dirty_sel), 1);
      chk("t2_noevict", 32'(rpb_load_line), 0);
      adv();
    end
    rpb_full = 0;
    settle(); adv();
    settle(); chk("t2_evict", 32'(rpb_load_line), 1); adv();
    settle(); chk("t2_fill_data", 32'(load_data), 1); chk("t2_fill_inc", 32'(inc_mshr_ptr), 1); adv();

    // full RPB forces writeback ahead of a pending fill
    do_reset();
    rpb_full = 1; rpb_wait = 1; mshr_wait = 1;
    settle(); adv();
    settle(); chk("t3_wr", 32'(pmem_write), 1); chk("t3_rw_sel", 32'(rw_sel), 0); adv();
    rpb_wait = 0; rpb_full = 0; mshr_wait = 0; pmem_resp = 1;
    settle(); chk("t3_inc_rpb", 32'(inc_rpb_ptr), 1); adv();
    pmem_resp = 0;
    settle(); adv();

    // starvation: exactly LIM fills before a writeback is forced
    do_reset();
    mshr_wait = 1; rpb_wait = 1; fill_grant = 1; pmem_resp = 1;
    nfill = 0; seen_wr = 0;
    for (int i = 0; i < 200 && !seen_wr; i++) begin
      settle();
      if (inc_mshr_ptr) nfill++;
      if (pmem_write) begin
        seen_wr = 1;
        chk("t4_rw_sel", 32'(rw_sel), 0);
        chk("t4_inc_rpb", 32'(inc_rpb_ptr), 1);
      end
      adv();
    end
    chk("t4_write_seen", 32'(seen_wr), 1);
    chk("t4_fills", 32'(nfill), LIM);

    // reset in the middle of a read
    do_reset();
    mshr_wait = 1;
    settle(); adv();
    mshr_wait = 0;
    settle(); chk("t5_in_read", 32'(pmem_read), 1); adv();
    reset = 1; pmem_resp = 1; mll_seen = 0;
    settle(); mll_seen = mll_seen | mshr_load_line; adv();
    reset = 0; pmem_resp = 0;
    settle();
    mll_seen = mll_seen | mshr_load_line;
    chk("t5_rst_vec", 32'(obs()), 32'(RST_VEC));
    chk("t5_rd_off", 32'(pmem_read), 0);
    adv();
    chk("t5_no_mll", 32'(mll_seen), 0);

    // merged-dirty fill into way0
    do_reset();
    mshr_wait = 1; mshr_dirty = 1; fill_grant = 1;
    settle(); adv();
    mshr_wait = 0; pmem_resp = 1;
    settle(); adv();
    pmem_resp = 0;
    settle(); adv();
    settle();
    chk("t6_dirty_in", 32'(dirty_in), 1);
    chk("t6_load_dirty", 32'(load_dirty), 1);
    chk("t6_lru_in", 32'(lru_in), 1);
    adv();

    // random traffic with an environment that tracks MSHR/RPB occupancy
    do_reset();
    fills = 0; wbs = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0 && fills < 4) fills++;
      if ($urandom_range(0, 11) == 0 && wbs < 2) wbs++;
      mshr_wait    = (fills > 0);
      rpb_wait     = (wbs > 0);
      rpb_full     = (wbs >= 2);
      pmem_resp    = (ph == PH_MEMRD || ph == PH_MEMWR) ? ($urandom_range(0, 2) == 0)
                                                        : ($urandom_range(0, 7) == 0);
      fill_grant   = 1'($urandom_range(0, 1));
      lru_out      = 1'($urandom_range(0, 1));
      victim_dirty = 2'($urandom_range(0, 3));
      mshr_dirty   = 1'($urandom_range(0, 1));
      settle();
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
